// File: rtl/mem_access_ctrl.sv
// Load/store initiator for a word-indexed data memory: big-endian byte lanes,
// sub-word stores done as read-modify-write, all outputs registered.
module mem_access_ctrl #(
  parameter int DEPTH = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  input  logic [31:0] MemData
);

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  state_t      state, nxt;
  logic        dec, n_dec, latch;
  logic        r_write, r_signed;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata;
  logic        n_rready, n_rvalid, n_err, n_mr, n_mw;
  logic [31:0] n_rdata, n_addr, n_wd;

  logic [29:0] idx;
  logic [1:0]  off;
  logic        err;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_val, st_word;

  assign idx = r_addr[31:2];
  assign off = r_addr[1:0];
  assign err = (r_size == 2'b11) ||
               (r_size == 2'b01 && off[0]) ||
               (r_size == 2'b10 && off != 2'b00) ||
               ({2'b00, idx} >= 32'(DEPTH));

  // Field extraction and merge against the word presented during RD.
  always_comb begin
    ld_b = 8'h0;
    case (off)
      2'd0:    ld_b = MemData[31:24];
      2'd1:    ld_b = MemData[23:16];
      2'd2:    ld_b = MemData[15:8];
      default: ld_b = MemData[7:0];
    endcase
    ld_h = off[1] ? MemData[15:0] : MemData[31:16];
    case (r_size)
      2'b00:   ld_val = r_signed ? {{24{ld_b[7]}}, ld_b} : {24'h0, ld_b};
      2'b01:   ld_val = r_signed ? {{16{ld_h[15]}}, ld_h} : {16'h0, ld_h};
      default: ld_val = MemData;
    endcase
  end

  always_comb begin
    st_word = MemData;
    case (r_size)
      2'b00:
        case (off)
          2'd0:    st_word[31:24] = r_wdata[7:0];
          2'd1:    st_word[23:16] = r_wdata[7:0];
          2'd2:    st_word[15:8]  = r_wdata[7:0];
          default: st_word[7:0]   = r_wdata[7:0];
        endcase
      2'b01:
        if (off[1]) st_word[15:0]  = r_wdata[15:0];
        else        st_word[31:16] = r_wdata[15:0];
      default: st_word = r_wdata;
    endcase
  end

  // dec marks the cycle after acceptance, when the latched request is decoded;
  // state tracks which strobe is currently on the memory port.
  always_comb begin
    nxt      = state;
    n_dec    = 1'b0;
    latch    = 1'b0;
    n_rready = req_ready;
    n_rvalid = rsp_valid;
    n_rdata  = rsp_rdata;
    n_err    = rsp_err;
    n_mr     = 1'b0;
    n_mw     = 1'b0;
    n_addr   = Address;
    n_wd     = WriteData;
    case (state)
      IDLE: begin
        if (dec) begin
          if (err) begin
            nxt      = RSP;
            n_rvalid = 1'b1;
            n_err    = 1'b1;
            n_rdata  = 32'h0;
          end else if (!r_write || r_size != 2'b10) begin
            nxt    = RD;
            n_mr   = 1'b1;
            n_addr = {2'b00, idx};
          end else begin
            nxt    = WR;
            n_mw   = 1'b1;
            n_addr = {2'b00, idx};
            n_wd   = r_wdata;
          end
        end else if (req_valid && req_ready) begin
          latch    = 1'b1;
          n_dec    = 1'b1;
          n_rready = 1'b0;
        end
      end
      RD: begin
        if (!r_write) begin
          nxt      = RSP;
          n_rvalid = 1'b1;
          n_err    = 1'b0;
          n_rdata  = ld_val;
        end else begin
          nxt  = WR;
          n_mw = 1'b1;
          n_wd = st_word;
        end
      end
      WR: begin
        nxt      = RSP;
        n_rvalid = 1'b1;
        n_err    = 1'b0;
        n_rdata  = 32'h0;
      end
      default: begin
        if (rsp_ready) begin
          nxt      = IDLE;
          n_rvalid = 1'b0;
          n_rready = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dec       <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      Address   <= 32'h0;
      WriteData <= 32'h0;
    end else begin
      state     <= nxt;
      dec       <= n_dec;
      req_ready <= n_rready;
      rsp_valid <= n_rvalid;
      rsp_rdata <= n_rdata;
      rsp_err   <= n_err;
      MemRead   <= n_mr;
      MemWrite  <= n_mw;
      Address   <= n_addr;
      WriteData <= n_wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write  <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
    end else if (latch) begin
      r_write  <= req_write;
      r_size   <= req_size;
      r_signed <= req_signed;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural word memory.
module tb_mem_access_ctrl;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        MemRead, MemWrite;
  logic [31:0] Address, WriteData, MemData;

  logic [31:0] mem [256];
  int checks = 0, errors = 0;
  int rd_cnt, wr_cnt, both_cnt;
  logic [31:0] rd_addr, wr_addr, wr_data;
  int lat;
  logic [31:0] r_data;
  logic        r_err;

  mem_access_ctrl #(.DEPTH(200)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .MemRead(MemRead),
    .MemWrite(MemWrite), .Address(Address), .WriteData(WriteData),
    .MemData(MemData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign MemData = (MemRead && Address < 32'd200) ? mem[Address[7:0]] : 32'h0;

  always @(posedge clk)
    if (MemWrite && Address < 32'd200) mem[Address[7:0]] <= WriteData;

  always @(negedge clk) begin
    if (MemRead)  begin rd_cnt++; rd_addr = Address; end
    if (MemWrite) begin wr_cnt++; wr_addr = Address; wr_data = WriteData; end
    if (MemRead && MemWrite) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for the response, let the handshake complete.
  task automatic send(input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rd_cnt = 0; wr_cnt = 0;
    lat = 0;
    do begin @(posedge clk); lat++; #1; end while (!rsp_valid && lat < 20);
    if (!rsp_valid) lat = 99;
    r_data = rsp_rdata;
    r_err  = rsp_err;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
    rd_addr = 0; wr_addr = 0; wr_data = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_memrw", {30'h0, MemRead, MemWrite}, 32'h0);
    chk("rst_addr_wd", Address | WriteData, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // word store
    send(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("wst_lat", lat, 2);
    chk("wst_err", 32'(r_err), 32'd0);
    chk("wst_wrcnt", wr_cnt, 1);
    chk("wst_rdcnt", rd_cnt, 0);
    chk("wst_addr", wr_addr, 32'd4);
    chk("wst_data", wr_data, 32'hDEADBEEF);
    chk("wst_idle_ready", 32'(req_ready), 32'd1);
    chk("wst_rsp_drop", 32'(rsp_valid), 32'd0);

    // loads
    send(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
    chk("lb_s_data", r_data, 32'hFFFFFFDE);
    chk("lb_s_lat", lat, 2);
    chk("lb_s_rdcnt", rd_cnt, 1);
    chk("lb_s_addr", rd_addr, 32'd4);
    send(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    chk("lb_u_data", r_data, 32'h000000EF);
    send(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    chk("lb_s1_data", r_data, 32'hFFFFFFAD);
    send(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    chk("lh_s_data", r_data, 32'hFFFFBEEF);
    chk("lh_s_rdcnt", rd_cnt, 1);
    send(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    chk("lh_u_data", r_data, 32'h0000DEAD);
    send(1'b0, 2'b10, 1'b1, 32'h10, 32'h0);
    chk("lw_data", r_data, 32'hDEADBEEF);
    chk("lw_addr", rd_addr, 32'd4);

    // sub-word stores (read-modify-write)
    send(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234);
    chk("sh_lat", lat, 3);
    chk("sh_rdcnt", rd_cnt, 1);
    chk("sh_wrcnt", wr_cnt, 1);
    chk("sh_rdaddr", rd_addr, 32'd4);
    chk("sh_wdata", wr_data, 32'hDEAD1234);
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("sh_readback", r_data, 32'hDEAD1234);
    send(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF55);
    chk("sb_wdata", wr_data, 32'hDE551234);
    chk("sb_lat", lat, 3);

    // top legal index
    send(1'b1, 2'b10, 1'b0, 32'h31C, 32'hA5A50F0F);
    chk("top_st_err", 32'(r_err), 32'd0);
    chk("top_st_addr", wr_addr, 32'd199);
    send(1'b0, 2'b10, 1'b0, 32'h31C, 32'h0);
    chk("top_ld_data", r_data, 32'hA5A50F0F);

    // errors
    send(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
    chk("e_wmis_err", 32'(r_err), 32'd1);
    chk("e_wmis_data", r_data, 32'h0);
    chk("e_wmis_lat", lat, 1);
    chk("e_wmis_mem", rd_cnt + wr_cnt, 0);
    send(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000FFFF);
    chk("e_hmis_err", 32'(r_err), 32'd1);
    chk("e_hmis_lat", lat, 1);
    chk("e_hmis_mem", rd_cnt + wr_cnt, 0);
    send(1'b0, 2'b10, 1'b0, 32'h320, 32'h0);
    chk("e_range_err", 32'(r_err), 32'd1);
    chk("e_range_data", r_data, 32'h0);
    chk("e_range_mem", rd_cnt + wr_cnt, 0);
    send(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    chk("e_size_err", 32'(r_err), 32'd1);
    chk("e_size_lat", lat, 1);
    chk("e_size_mem", rd_cnt + wr_cnt, 0);

    // back-pressure: A = word load 0x10, B queued behind it
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk); #1;
    rd_cnt = 0;
    req_size = 2'b00; req_addr = 32'h13;
    lat = 0;
    do begin @(posedge clk); lat++; #1; end while (!rsp_valid && lat < 20);
    chk("bp_lat", lat, 2);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_data", rsp_rdata, 32'hDE551234);
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    chk("bp_no_second_rd", rd_cnt, 1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_drop_valid", 32'(rsp_valid), 32'd0);
    chk("bp_ready_back", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    do begin @(posedge clk); lat++; #1; end while (!rsp_valid && lat < 20);
    chk("bp_b_lat", lat, 2);
    chk("bp_b_data", rsp_rdata, 32'h00000034);
    @(posedge clk); #1;

    // reset during WR
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h20;
    req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rwr_memwrite_hi", 32'(MemWrite), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rwr_memwrite_drop", 32'(MemWrite), 32'd0);
    chk("rwr_ready", 32'(req_ready), 32'd1);
    chk("rwr_outs", Address | WriteData | rsp_rdata, 32'h0);
    chk("rwr_flags", {29'h0, rsp_valid, rsp_err, MemRead}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_data", r_data, 32'hDE551234);
    chk("no_rd_wr_overlap", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
